// File: rtl/aes_128_decrypt.sv
// AES-128 block decryptor, iterative: one inverse round per clock, round keys
// unrolled backwards on the fly from rk10. Latency: 22 cycles start->done on a key-cache miss, 12 on a hit.
// Backpressure: none. start_decrypt is sampled only in IDLE and ignored while busy.
//
// Ports:
//   clk, rst_n     rising-edge clock; asynchronous active-low reset
//   start_decrypt  request, accepted when the block is IDLE
//   ciphertext_in  128-bit block to decrypt, captured on acceptance
//   key_in         128-bit cipher key, captured on acceptance
//   plaintext_out  registered result, held until the next completion
//   decrypt_done   one-cycle completion pulse
//   busy           high in every state except IDLE
module aes_128_decrypt (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start_decrypt,
  input  logic [127:0] ciphertext_in,
  input  logic [127:0] key_in,
  output logic [127:0] plaintext_out,
  output logic         decrypt_done,
  output logic         busy
);

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    KEY_FWD  = 3'd1,
    INIT_ADD = 3'd2,
    ROUNDS   = 3'd3,
    FINAL    = 3'd4,
    DONE     = 3'd5
  } fsm_e;

  // ---------------------------------------------------------------------------
  // GF(2^8) arithmetic and S-boxes. The S-boxes are computed from the field
  // inverse plus the affine map rather than stored as tables; the functions
  // only ever see a fixed input set, so synthesis folds them to 8-in logic.
  // ---------------------------------------------------------------------------
  function automatic logic [7:0] xtime(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] acc;
    logic [7:0] p;
    acc = 8'h00;
    p   = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) acc = acc ^ p;
      p = xtime(p);
    end
    return acc;
  endfunction

  // a^254 == a^-1 in GF(2^8); maps 0 to 0 as AES requires.
  function automatic logic [7:0] gf_inv(input logic [7:0] a);
    logic [7:0] r;
    logic [7:0] p;
    r = 8'h01;
    p = a;
    for (int i = 0; i < 8; i++) begin
      if (i != 0) r = gf_mul(r, p);
      p = gf_mul(p, p);
    end
    return r;
  endfunction

  function automatic logic [7:0] sbox(input logic [7:0] x);
    logic [7:0] b;
    b = gf_inv(x);
    return b ^ {b[6:0], b[7]} ^ {b[5:0], b[7:6]} ^ {b[4:0], b[7:5]} ^ {b[3:0], b[7:4]} ^ 8'h63;
  endfunction

  // Undo the affine map first (rotations by 1, 3, 6 and constant 05), then invert.
  function automatic logic [7:0] inv_sbox(input logic [7:0] y);
    return gf_inv({y[6:0], y[7]} ^ {y[4:0], y[7:5]} ^ {y[1:0], y[7:2]} ^ 8'h05);
  endfunction

  function automatic logic [31:0] sub_rot_word(input logic [31:0] w);
    return {sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0]), sbox(w[31:24])};
  endfunction

  function automatic logic [7:0] rcon(input logic [3:0] i);
    logic [7:0] r;
    case (i)
      4'd1:    r = 8'h01;
      4'd2:    r = 8'h02;
      4'd3:    r = 8'h04;
      4'd4:    r = 8'h08;
      4'd5:    r = 8'h10;
      4'd6:    r = 8'h20;
      4'd7:    r = 8'h40;
      4'd8:    r = 8'h80;
      4'd9:    r = 8'h1b;
      4'd10:   r = 8'h36;
      default: r = 8'h00;
    endcase
    return r;
  endfunction

  // rk_i -> rk_{i+1}
  function automatic logic [127:0] key_fwd(input logic [127:0] rk, input logic [7:0] rc);
    logic [31:0] w0, w1, w2, w3;
    w0 = rk[127:96] ^ sub_rot_word(rk[31:0]) ^ {rc, 24'h000000};
    w1 = rk[95:64] ^ w0;
    w2 = rk[63:32] ^ w1;
    w3 = rk[31:0]  ^ w2;
    return {w0, w1, w2, w3};
  endfunction

  // rk_{i+1} -> rk_i, where rc is the Rcon that produced rk_{i+1}
  function automatic logic [127:0] key_inv(input logic [127:0] rk, input logic [7:0] rc);
    logic [31:0] w0, w1, w2, w3;
    w3 = rk[31:0]  ^ rk[63:32];
    w2 = rk[63:32] ^ rk[95:64];
    w1 = rk[95:64] ^ rk[127:96];
    w0 = rk[127:96] ^ sub_rot_word(w3) ^ {rc, 24'h000000};
    return {w0, w1, w2, w3};
  endfunction

  // Byte i sits at bits [127-8i -: 8]; row = i%4, column = i/4.
  // Row r rotates right by r: out[r][c] = in[r][(c-r) mod 4].
  function automatic logic [127:0] inv_shift_rows(input logic [127:0] s);
    logic [127:0] o;
    o = '0;
    for (int i = 0; i < 16; i++) begin
      o[127-8*i -: 8] = s[127-8*((i % 4) + 4*(((i / 4) + 4 - (i % 4)) % 4)) -: 8];
    end
    return o;
  endfunction

  function automatic logic [127:0] inv_sub_bytes(input logic [127:0] s);
    logic [127:0] o;
    o = '0;
    for (int i = 0; i < 16; i++) o[127-8*i -: 8] = inv_sbox(s[127-8*i -: 8]);
    return o;
  endfunction

  function automatic logic [127:0] inv_mix_columns(input logic [127:0] s);
    logic [127:0] o;
    logic [7:0]   a0, a1, a2, a3;
    o = '0;
    for (int c = 0; c < 4; c++) begin
      a0 = s[127-32*c -: 8];
      a1 = s[119-32*c -: 8];
      a2 = s[111-32*c -: 8];
      a3 = s[103-32*c -: 8];
      o[127-32*c -: 8] = gf_mul(a0, 8'h0e) ^ gf_mul(a1, 8'h0b) ^ gf_mul(a2, 8'h0d) ^ gf_mul(a3, 8'h09);
      o[119-32*c -: 8] = gf_mul(a0, 8'h09) ^ gf_mul(a1, 8'h0e) ^ gf_mul(a2, 8'h0b) ^ gf_mul(a3, 8'h0d);
      o[111-32*c -: 8] = gf_mul(a0, 8'h0d) ^ gf_mul(a1, 8'h09) ^ gf_mul(a2, 8'h0e) ^ gf_mul(a3, 8'h0b);
      o[103-32*c -: 8] = gf_mul(a0, 8'h0b) ^ gf_mul(a1, 8'h0d) ^ gf_mul(a2, 8'h09) ^ gf_mul(a3, 8'h0e);
    end
    return o;
  endfunction

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  fsm_e         fsm_q, fsm_d;
  logic [3:0]   round_q, round_d;
  logic [127:0] blk_q, blk_d;             // AES state; holds the ciphertext until INIT_ADD
  logic [127:0] rk_q, rk_d;               // round-key register
  logic         cache_valid_q, cache_valid_d;
  logic [127:0] cache_key_q, cache_key_d;
  logic [127:0] cache_rk_q, cache_rk_d;   // rk10 of cache_key_q
  logic [127:0] pt_q, pt_d;
  logic         done_q, done_d;

  logic [127:0] rk_fwd;
  logic [127:0] rk_cur;
  logic         cache_hit;

  // While decrypting, rk_q holds rk_{round+1}; rk_cur is the key for this round.
  // In FINAL round_q is 0, so rk_cur is rk0 derived from rk1 with Rcon(1).
  assign rk_fwd    = key_fwd(rk_q, rcon(round_q));
  assign rk_cur    = key_inv(rk_q, rcon(round_q + 4'd1));
  assign cache_hit = cache_valid_q && (key_in == cache_key_q);

  always_comb begin
    fsm_d         = fsm_q;
    round_d       = round_q;
    blk_d         = blk_q;
    rk_d          = rk_q;
    cache_valid_d = cache_valid_q;
    cache_key_d   = cache_key_q;
    cache_rk_d    = cache_rk_q;
    pt_d          = pt_q;
    done_d        = 1'b0;

    case (fsm_q)
      IDLE: begin
        if (start_decrypt) begin
          blk_d = ciphertext_in;
          if (cache_hit) begin
            rk_d  = cache_rk_q;
            fsm_d = INIT_ADD;
          end else begin
            // The cache key is overwritten now and only marked valid once
            // its rk10 has been computed at the end of KEY_FWD.
            rk_d          = key_in;
            cache_key_d   = key_in;
            cache_valid_d = 1'b0;
            round_d       = 4'd1;
            fsm_d         = KEY_FWD;
          end
        end
      end
      KEY_FWD: begin
        rk_d = rk_fwd;
        if (round_q == 4'd10) begin
          cache_rk_d    = rk_fwd;
          cache_valid_d = 1'b1;
          fsm_d         = INIT_ADD;
        end else begin
          round_d = round_q + 4'd1;
        end
      end
      INIT_ADD: begin
        blk_d   = blk_q ^ rk_q;
        round_d = 4'd9;
        fsm_d   = ROUNDS;
      end
      ROUNDS: begin
        blk_d = inv_mix_columns(inv_sub_bytes(inv_shift_rows(blk_q)) ^ rk_cur);
        rk_d  = rk_cur;
        if (round_q == 4'd1) begin
          round_d = 4'd0;
          fsm_d   = FINAL;
        end else begin
          round_d = round_q - 4'd1;
        end
      end
      FINAL: begin
        blk_d = inv_sub_bytes(inv_shift_rows(blk_q)) ^ rk_cur;
        rk_d  = rk_cur;
        fsm_d = DONE;
      end
      DONE: begin
        pt_d   = blk_q;
        done_d = 1'b1;
        fsm_d  = IDLE;
      end
      default: begin
        fsm_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fsm_q         <= IDLE;
      round_q       <= 4'd0;
      blk_q         <= '0;
      rk_q          <= '0;
      cache_valid_q <= 1'b0;
      cache_key_q   <= '0;
      cache_rk_q    <= '0;
      pt_q          <= '0;
      done_q        <= 1'b0;
    end else begin
      fsm_q         <= fsm_d;
      round_q       <= round_d;
      blk_q         <= blk_d;
      rk_q          <= rk_d;
      cache_valid_q <= cache_valid_d;
      cache_key_q   <= cache_key_d;
      cache_rk_q    <= cache_rk_d;
      pt_q          <= pt_d;
      done_q        <= done_d;
    end
  end

  assign plaintext_out = pt_q;
  assign decrypt_done  = done_q;
  assign busy          = (fsm_q != IDLE);

endmodule

// File: doc/aes_128_decrypt.md
AES_128_DECRYPT -- requirements
Module: aes_128_decrypt

Interface
REQ-001 The block SHALL have the port clk, input, 1 bit: rising-edge clock for all state.
REQ-002 The block SHALL have the port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-003 The block SHALL have the port start_decrypt, input, 1 bit: request pulse, sampled only in IDLE.
REQ-004 The block SHALL have the port ciphertext_in, input, 128 bits: block to decrypt, captured when start is accepted.
REQ-005 The block SHALL have the port key_in, input, 128 bits: cipher key (round key 0), captured when start is accepted.
REQ-006 The block SHALL have the port plaintext_out, output, 128 bits: registered result, held until the next completion.
REQ-007 The block SHALL have the port decrypt_done, output, 1 bit: one-cycle completion pulse.
REQ-008 The block SHALL have the port busy, output, 1 bit: high in every state except IDLE.

Function
REQ-009 Byte order SHALL follow FIPS-197: byte 0 = bits [127:120], column-major state, word 0 = bits [127:96].
REQ-010 States SHALL be IDLE, KEY_FWD, INIT_ADD, ROUNDS, FINAL and DONE, with a 4-bit round counter.
REQ-011 IDLE transition: on start_decrypt=1 the block SHALL latch ciphertext_in and key_in. It SHALL go to INIT_ADD if the key cache hits (REQ-017), otherwise to KEY_FWD with round=1.
REQ-012 KEY_FWD SHALL run the forward key schedule one round per cycle (round 1..10, Rcon 01,02,04,08,10,20,40,80,1b,36). After 10 cycles the round-key register SHALL hold round key 10, the cache SHALL be loaded with {key, rk10}, and the state SHALL move to INIT_ADD.
REQ-013 INIT_ADD SHALL take 1 cycle: state_reg = ciphertext ^ rk10, round=9, then go to ROUNDS.
REQ-014 ROUNDS SHALL take 1 cycle per round for round 9 down to 1 (9 cycles).
- Datapath: state_reg = InvMixColumns(InvSubBytes(InvShiftRows(state_reg)) ^ rk_round).
- After round 1 the state SHALL go to FINAL.
REQ-015 Round keys SHALL be derived backwards combinationally each cycle from the current key register (holding rk_{r+1} = w0'..w3').
- w3 = w3'^w2', w2 = w2'^w1', w1 = w1'^w0'.
- w0 = w0' ^ SubWord(RotWord(w3)) ^ Rcon(r+1).
- The result SHALL be registered as the key for the next round, so that rk0 is present in FINAL.
REQ-016 FINAL SHALL take 1 cycle: state_reg = InvSubBytes(InvShiftRows(state_reg)) ^ rk0, then go to DONE.
REQ-017 Key cache: cache_valid plus the stored key and rk10.
- A hit SHALL require cache_valid=1 and key_in equal to the stored key at start acceptance.
- A hit SHALL load rk10 from the cache and skip KEY_FWD.
REQ-018 DONE SHALL register plaintext_out <= state_reg, assert decrypt_done for exactly 1 cycle, and return to IDLE.
REQ-019 Latency from the start-sampling edge to the decrypt_done-high edge SHALL be 22 cycles on a cache miss and 12 cycles on a hit.
REQ-020 start_decrypt SHALL be ignored while busy=1, with no effect on in-flight data. start_decrypt held high continuously SHALL begin a new operation on the first IDLE cycle after DONE.
REQ-021 Input changes on ciphertext_in/key_in after acceptance SHALL NOT affect the in-flight result.
REQ-022 Illegal state encodings SHALL return to IDLE on the next clock.

Reset
REQ-023 On rst_n=0, at any time including mid-operation, the block SHALL immediately clear the following:
- state=IDLE, round=0;
- plaintext_out=0, decrypt_done=0, busy=0;
- state_reg=0, round-key register=0, cache_valid=0.
REQ-024 After rst_n deasserts, the first accepted start SHALL take the cache-miss path.

Verification
REQ-025 FIPS-197 C.1 cache miss: key 000102030405060708090a0b0c0d0e0f, ct 69c4e0d86a7b0430d8cdb78070b4c55a -> plaintext_out 00112233445566778899aabbccddeeff, decrypt_done 22 cycles after start.
REQ-026 Cache hit, same key: ct 69c4e0d86a7b0430d8cdb78070b4c55a -> same plaintext, done after 12 cycles. Then FIPS-197 App. B key 2b7e151628aed2a6abf7158809cf4f3c, ct 3925841d02dc09fbdc118597196a0b32 -> 3243f6a8885a308d313198a2e0370734 after 22 cycles.
REQ-027 start_decrypt pulsed mid-ROUNDS with different ct/key, and inputs changed after acceptance -> original result unchanged, exactly one decrypt_done pulse.
REQ-028 rst_n asserted during ROUNDS -> all outputs 0 immediately, no decrypt_done. Next start with the C.1 key SHALL take 22 cycles and produce the correct plaintext.
REQ-029 start_decrypt held high for 60 cycles -> back-to-back operations, done pulses 1 cycle wide. Done spacing SHALL be 22 cycles for the first operation, then 13 (12 + the return to IDLE) for cache-hit operations.
